// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply/divide sequencer that owns the HI/LO pair.
// Signed operations run on magnitudes; the sign fix-up happens in a single FIX cycle.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wd,
    input  logic        mf_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        dz,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opd_reg, opd_next;
    logic [31:0] a_raw_reg, a_raw_next;
    logic        is_div_reg, is_div_next;
    logic        sign_a_reg, sign_a_next;
    logic        sign_b_reg, sign_b_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic        done_reg, done_next;
    logic        dz_reg, dz_next;

    // Operand magnitudes: signed ops (op[0]==0) take two's-complement absolute values.
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;

    assign a_neg = ~op[0] & a[31];
    assign b_neg = ~op[0] & b[31];
    assign mag_a = a_neg ? (~a + 32'd1) : a;
    assign mag_b = b_neg ? (~b + 32'd1) : b;

    // One shift-add multiply step: acc = {partial product, remaining multiplier bits}.
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    assign mul_sum  = {1'b0, acc_reg[63:32]} + {1'b0, opd_reg};
    assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[31:1]} : {1'b0, acc_reg[63:1]};

    // One restoring divide step: acc = {remainder, dividend/quotient}.
    // The shifted remainder can reach 33 bits, so the trial subtract is 34 bits wide.
    logic [33:0] div_diff;
    logic [63:0] div_step;

    assign div_diff = {1'b0, acc_reg[63:31]} - {2'b00, opd_reg};
    assign div_step = div_diff[33] ? {acc_reg[62:0], 1'b0}
                                   : {div_diff[31:0], acc_reg[30:0], 1'b1};

    // Sign fix-up values used in FIX.
    logic        signs_differ;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign signs_differ = sign_a_reg ^ sign_b_reg;
    assign prod_fix     = signs_differ ? (~acc_reg + 64'd1) : acc_reg;
    assign quo_fix      = signs_differ ? (~acc_reg[31:0] + 32'd1) : acc_reg[31:0];
    assign rem_fix      = sign_a_reg ? (~acc_reg[63:32] + 32'd1) : acc_reg[63:32];

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        opd_next    = opd_reg;
        a_raw_next  = a_raw_reg;
        is_div_next = is_div_reg;
        sign_a_next = sign_a_reg;
        sign_b_next = sign_b_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        done_next   = 1'b0;
        dz_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    is_div_next = op[1];
                    sign_a_next = a_neg;
                    sign_b_next = b_neg;
                    a_raw_next  = a;
                    cnt_next    = 5'd0;
                    if (op[1]) begin
                        acc_next = {32'd0, mag_a};
                        opd_next = mag_b;
                    end else begin
                        acc_next = {32'd0, mag_b};
                        opd_next = mag_a;
                    end
                    state_next = CALC;
                end else begin
                    if (mthi) hi_next = wd;
                    if (mtlo) lo_next = wd;
                end
            end

            CALC: begin
                acc_next = is_div_reg ? div_step : mul_step;
                cnt_next = cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    state_next = FIX;
                end
            end

            FIX: begin
                done_next  = 1'b1;
                state_next = IDLE;
                if (!is_div_reg) begin
                    hi_next = prod_fix[63:32];
                    lo_next = prod_fix[31:0];
                end else if (opd_reg == 32'd0) begin
                    // Divide by zero: report the raw dividend rather than the loop's residue.
                    hi_next = a_raw_reg;
                    lo_next = 32'hFFFF_FFFF;
                    dz_next = 1'b1;
                end else begin
                    hi_next = rem_fix;
                    lo_next = quo_fix;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 5'd0;
            acc_reg    <= 64'd0;
            opd_reg    <= 32'd0;
            a_raw_reg  <= 32'd0;
            is_div_reg <= 1'b0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            hi_reg     <= 32'd0;
            lo_reg     <= 32'd0;
            done_reg   <= 1'b0;
            dz_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            opd_reg    <= opd_next;
            a_raw_reg  <= a_raw_next;
            is_div_reg <= is_div_next;
            sign_a_reg <= sign_a_next;
            sign_b_reg <= sign_b_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            done_reg   <= done_next;
            dz_reg     <= dz_next;
        end
    end

    assign hi    = hi_reg;
    assign lo    = lo_reg;
    assign busy  = (state_reg != IDLE);
    assign done  = done_reg;
    assign dz    = dz_reg;
    assign stall = busy & (start | mthi | mtlo | mf_req);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table of full operations plus hand-written
// sequences for MT writes, stalls, dropped requests and asynchronous reset.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wd;
    logic        mf_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        dz;
    logic        stall;

    int checks;
    int errors;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wd     (wd),
        .mf_req (mf_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .stall  (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic        exp_dz;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, actual, expected);
        end
    endtask

    // Launch one operation, measure latency and busy length, then check the result.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
        end
        check({name, " latency"}, n, 34);
        check({name, " busy_cycles"}, busy_cnt, 33);
        check({name, " hi"}, hi, exp_hi);
        check({name, " lo"}, lo, exp_lo);
        check({name, " dz"}, {31'd0, dz}, {31'd0, exp_dz});
        $display("op %0d a=%08h b=%08h -> hi=%08h lo=%08h dz=%0d cycles=%0d", o, va, vb, hi, lo, dz, n);
        @(negedge clk);
        check({name, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    // Wait (bounded) for done, sampling on negedges.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " done_seen"}, {31'd0, done}, 32'd1);
    endtask

    initial begin
        int done_cnt;
        checks = 0;
        errors = 0;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[4]  = '{OP_DIVU,  32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{OP_DIV,   32'hFFFFFF9C, 32'h00000000, 32'hFFFFFF9C, 32'hFFFFFFFF, 1'b1};
        vecs[6]  = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[7]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
        vecs[8]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[10] = '{OP_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi = 1'b0; mtlo = 1'b0; wd = '0; mf_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset dz", {31'd0, dz}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);
        end

        // MTHI+MTLO together in IDLE, then MTHI alone.
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wd = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both hi", hi, 32'h12345678);
        check("mt_both lo", lo, 32'h12345678);
        $display("mthi+mtlo wd=12345678 -> hi=%08h lo=%08h", hi, lo);
        mthi = 1'b1; wd = 32'hAAAA5555;
        @(negedge clk);
        mthi = 1'b0;
        check("mthi_only hi", hi, 32'hAAAA5555);
        check("mthi_only lo", lo, 32'h12345678);

        // start together with MT writes: start wins, MT write dropped.
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        mthi = 1'b1; mtlo = 1'b1; wd = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("start_mt busy", {31'd0, busy}, 32'd1);
        check("start_mt hi_held", hi, 32'hAAAA5555);
        check("start_mt lo_held", lo, 32'h12345678);
        wait_done("start_mt");
        check("start_mt hi", hi, 32'd0);
        check("start_mt lo", lo, 32'd15);
        $display("start+mt MULTU 3*5 -> hi=%08h lo=%08h", hi, lo);

        // Requests during CALC stall and are ignored.
        @(negedge clk);
        start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        mf_req = 1'b1;
        #1 check("stall mf_req", {31'd0, stall}, 32'd1);
        @(negedge clk);
        mf_req = 1'b0; mthi = 1'b1; wd = 32'h00000111;
        #1 check("stall mthi", {31'd0, stall}, 32'd1);
        @(negedge clk);
        mthi = 1'b0;
        check("stall hi_unchanged", hi, 32'd0);
        start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
        #1 check("stall start", {31'd0, stall}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        mf_req = 1'b1;
        wait_done("stall_seq");
        #1 check("stall done_cycle", {31'd0, stall}, 32'd0);
        mf_req = 1'b0;
        check("stall_seq hi", hi, 32'd0);
        check("stall_seq lo", lo, 32'd42);
        $display("stalled MULTU 6*7 -> hi=%08h lo=%08h", hi, lo);
        @(negedge clk);
        mf_req = 1'b1;
        #1 check("idle mf_req no_stall", {31'd0, stall}, 32'd0);
        mf_req = 1'b0;
        run_op("represented", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

        // Asynchronous reset at iteration 10 of a MULTU.
        start = 1'b1; op = OP_MULTU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_mid hi", hi, 32'd0);
        check("rst_mid lo", lo, 32'd0);
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_mid no_done", done_cnt, 32'd0);
        $display("reset mid-MULTU -> hi=%08h lo=%08h busy=%0d", hi, lo, busy);
        run_op("after_rst", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
